irq_ctrl_prio: RTL and testbench



---
 rtl/irq_ctrl_prio.sv | 91 +++++++++
 tb/tb_irq_ctrl_prio.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_prio.sv
// Fixed-priority interrupt controller: latches level/edge requests into a pending register,
// presents the lowest-index enabled source to the core and pulses int_fin on acknowledge.
module irq_ctrl_prio #(
  parameter int unsigned N_SRC         = 32,
  parameter logic [31:0] EDGE_MASK     = 32'h0,
  parameter int unsigned MCAUSE_OFFSET = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             INT_RST_i,
  output logic             INT_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o,
  output logic [N_SRC-1:0] pending_o
);

  localparam int unsigned      IdxW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] EdgeSel = EDGE_MASK[N_SRC-1:0];

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e           state_q;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] fin_q;
  logic [IdxW-1:0]  cur_idx_q;
  logic             int_q;
  logic [31:0]      mcause_q;

  logic [N_SRC-1:0] set;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] cand;
  logic [IdxW-1:0]  winner;
  logic             ack;
  logic [31:0]      mcause_d;

  always_comb begin
    set  = (EdgeSel & int_req_i & ~req_q) | (~EdgeSel & int_req_i);
    ack  = (state_q == StServe) && INT_RST_i;
    clr  = ack ? (N_SRC'(1) << cur_idx_q) : '0;
    cand = pending_q & mie_i;
    // Scan downwards so the lowest set index is the last one written.
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (cand[i]) winner = IdxW'(i);
    end
    mcause_d = {1'b1, 31'(MCAUSE_OFFSET + 32'(winner))};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pending_q <= '0;
      fin_q     <= '0;
      cur_idx_q <= '0;
      int_q     <= 1'b0;
      mcause_q  <= '0;
    end else begin
      req_q     <= int_req_i;
      // Set is OR-ed after the clear so a new request in the ack cycle survives.
      pending_q <= (pending_q & ~clr) | set;
      fin_q     <= clr;
      case (state_q)
        StIdle: begin
          if (|cand) begin
            cur_idx_q <= winner;
            mcause_q  <= mcause_d;
            int_q     <= 1'b1;
            state_q   <= StServe;
          end
        end
        StServe: begin
          if (INT_RST_i) begin
            int_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign INT_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_ctrl_prio.sv
// Bench for irq_ctrl_prio: directed scenarios with literal expectations plus a randomized run,
// all cycles compared against a cycle-level behavioural model of the controller.
module tb_irq_ctrl_prio;

  localparam int unsigned N     = 32;
  localparam logic [31:0] EMASK = 32'h1;
  localparam int unsigned OFS   = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  mie;
  logic          ack;
  logic          int_o;
  logic [31:0]   mcause;
  logic [N-1:0]  fin;
  logic [N-1:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_prio #(
    .N_SRC        (N),
    .EDGE_MASK    (EMASK),
    .MCAUSE_OFFSET(OFS)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .int_req_i(req),
    .mie_i    (mie),
    .INT_RST_i(ack),
    .INT_o    (int_o),
    .mcause_o (mcause),
    .int_fin_o(fin),
    .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one service slot, a pending set and the lowest-index rule.
  bit [N-1:0] m_pending;
  bit [N-1:0] m_prev;
  bit [N-1:0] m_fin;
  bit         m_busy;
  int         m_cur;
  bit         m_int;
  bit [31:0]  m_mcause;
  bit         m_started = 1'b0;

  always @(posedge clk) begin
    bit [N-1:0] newreq;
    bit [N-1:0] nxt;
    m_started = 1'b1;
    if (rst) begin
      m_pending = '0; m_prev = '0; m_fin = '0; m_busy = 0;
      m_cur = 0; m_int = 0; m_mcause = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (EMASK[i]) newreq[i] = req[i] && !m_prev[i];
        else          newreq[i] = req[i];
      end
      nxt   = m_pending;
      m_fin = '0;
      if (m_busy) begin
        if (ack) begin
          nxt[m_cur]   = 1'b0;
          m_fin[m_cur] = 1'b1;
          m_busy       = 0;
          m_int        = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_pending[i] && mie[i] && !m_busy) begin
            m_busy   = 1;
            m_cur    = i;
            m_int    = 1;
            m_mcause = 32'h8000_0000 | (OFS + i);
          end
        end
      end
      m_pending = nxt | newreq;
      m_prev    = req;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_int",     {31'b0, int_o}, {31'b0, m_int});
      chk("model_mcause",  mcause,         m_mcause);
      chk("model_fin",     fin,            m_fin);
      chk("model_pending", pending,        m_pending);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '1; mie = '0; ack = 1'b0;

    // Reset held two cycles with every request asserted.
    step(2);
    chk("rst_int",     {31'b0, int_o}, 32'h0);
    chk("rst_pending", pending,        32'h0);
    chk("rst_mcause",  mcause,         32'h0);
    chk("rst_fin",     fin,            32'h0);
    rst = 1'b0;
    step(1);
    chk("rst_release_pending", pending, 32'hFFFF_FFFF);
    chk("rst_release_int", {31'b0, int_o}, 32'h0);

    // Single level source 3.
    rst = 1'b1; req = '0; step(1); rst = 1'b0; mie = 32'h8;
    req = 32'h8; step(1);
    chk("lvl_pending", pending, 32'h8);
    chk("lvl_int_early", {31'b0, int_o}, 32'h0);
    req = '0; step(1);
    chk("lvl_int", {31'b0, int_o}, 32'h1);
    chk("lvl_mcause", mcause, 32'h8000_0013);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("lvl_fin", fin, 32'h8);
    chk("lvl_int_drop", {31'b0, int_o}, 32'h0);
    chk("lvl_pending_clr", pending, 32'h0);
    step(1);
    chk("lvl_fin_once", fin, 32'h0);

    // Priority without preemption.
    mie = '1; req = 32'h20; step(1); req = '0; step(1);
    chk("prio_mcause5", mcause, 32'h8000_0015);
    req = 32'h2; step(1); req = '0; step(1);
    chk("prio_hold", mcause, 32'h8000_0015);
    chk("prio_pending", pending, 32'h22);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("prio_gap", {31'b0, int_o}, 32'h0);
    chk("prio_fin5", fin, 32'h20);
    step(1);
    chk("prio_int1", {31'b0, int_o}, 32'h1);
    chk("prio_mcause1", mcause, 32'h8000_0011);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("prio_fin1", fin, 32'h2);
    step(1);

    // Edge source 0 held high for 10 cycles: one service only.
    req = 32'h1; step(2);
    chk("edge_mcause", mcause, 32'h8000_0010);
    step(3);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("edge_fin", fin, 32'h1);
    step(4);
    chk("edge_no_reserve", {31'b0, int_o}, 32'h0);
    chk("edge_no_repend", pending, 32'h0);
    req = '0; step(1);

    // New edge in the ack cycle survives the clear.
    req = 32'h1; step(1); req = '0; step(1);
    req = 32'h1; ack = 1'b1; step(1); ack = 1'b0; req = '0;
    chk("setwins_fin", fin, 32'h1);
    chk("setwins_pending", pending, 32'h1);
    step(1);
    chk("setwins_reserve", {31'b0, int_o}, 32'h1);
    ack = 1'b1; step(1); ack = 1'b0; step(1);

    // Masked source 7 waits until enabled.
    mie = '0; req = 32'h80; step(1); req = '0; step(20);
    chk("mask_int", {31'b0, int_o}, 32'h0);
    chk("mask_pending", pending, 32'h80);
    mie = 32'h80; step(1);
    chk("mask_int_rise", {31'b0, int_o}, 32'h1);
    chk("mask_mcause", mcause, 32'h8000_0017);
    ack = 1'b1; step(1); ack = 1'b0; step(1);

    // Spurious ack in idle.
    ack = 1'b1; step(1); ack = 1'b0;
    chk("spur_fin", fin, 32'h0);
    chk("spur_pending", pending, 32'h0);

    // Reset during service.
    mie = '1; req = 32'h4; step(1); req = 32'h10; step(1);
    chk("midrst_int", {31'b0, int_o}, 32'h1);
    rst = 1'b1; step(1); rst = 1'b0; req = '0;
    chk("midrst_int_drop", {31'b0, int_o}, 32'h0);
    chk("midrst_fin", fin, 32'h0);
    chk("midrst_pending", pending, 32'h0);
    step(1);
    chk("midrst_fin_after", fin, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = $urandom & $urandom & $urandom;
      mie = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom | $urandom);
      ack = ($urandom_range(0, 3) == 0);
      step(1);
    end
    rst = 1'b0; req = '0; ack = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
